// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: decodes the software control word, waits for a trigger,
// streams qualified samples into a BRAM and publishes a done/busy/wrapped/last-address status word.
module snap_capture_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
  input  logic              trig,
  input  logic              stop,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_out
);

  localparam int unsigned CTRL_ARM      = 0;
  localparam int unsigned CTRL_TRIG_IMM = 1;
  localparam int unsigned CTRL_WE_ALL   = 2;
  localparam int unsigned CTRL_CIRC     = 3;
  localparam int unsigned ST_DONE       = 31;
  localparam int unsigned ST_BUSY       = 30;
  localparam int unsigned ST_WRAPPED    = 29;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic              arm_q;
  logic              we_all_q;
  logic              circ_q;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              arm_rise_c;
  logic              wq_c;
  logic              wr_c;
  logic              wrapped_nxt;
  logic [ADDR_W-1:0] last_nxt;
  logic [31:0]       status_nxt;
  logic              unused_ctrl;

  assign unused_ctrl = ^ctrl_in[31:4];

  // Asynchronous assertion, synchronised release of the internal reset
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign arm_rise_c = ctrl_in[CTRL_ARM] & ~arm_q;
  assign wq_c       = we_all_q | din_valid;

  always_ff @(posedge user_clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state, write decision and next status fields; arm_rise overrides everything
  always_comb begin
    state_nxt   = state;
    wr_c        = 1'b0;
    cnt_nxt     = cnt;
    wrapped_nxt = status_out[ST_WRAPPED];
    last_nxt    = status_out[ADDR_W-1:0];
    if (arm_rise_c) begin
      state_nxt   = ctrl_in[CTRL_TRIG_IMM] ? CAPTURE : ARMED;
      cnt_nxt     = '0;
      wrapped_nxt = 1'b0;
      last_nxt    = '0;
    end else begin
      case (state)
        ARMED: begin
          if (trig) begin
            state_nxt = CAPTURE;
            wr_c      = wq_c;
          end
        end
        CAPTURE: begin
          if (circ_q && stop) state_nxt = DONE;
          else                wr_c      = wq_c;
        end
        default: ;
      endcase
      if (wr_c) begin
        cnt_nxt  = cnt + ADDR_W'(1);
        last_nxt = cnt;
        if (cnt == {ADDR_W{1'b1}}) begin
          if (circ_q) wrapped_nxt = 1'b1;
          else        state_nxt   = DONE;
        end
      end
    end
    status_nxt                = '0;
    status_nxt[ST_DONE]       = (state_nxt == DONE);
    status_nxt[ST_BUSY]       = (state_nxt == ARMED) || (state_nxt == CAPTURE);
    status_nxt[ST_WRAPPED]    = wrapped_nxt;
    status_nxt[ADDR_W-1:0]    = last_nxt;
  end

  always_ff @(posedge user_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      arm_q      <= 1'b0;
      we_all_q   <= 1'b0;
      circ_q     <= 1'b0;
      cnt        <= '0;
      bram_addr  <= '0;
      bram_we    <= 1'b0;
      bram_din   <= '0;
      status_out <= '0;
    end else begin
      arm_q      <= ctrl_in[CTRL_ARM];
      cnt        <= cnt_nxt;
      bram_we    <= wr_c;
      status_out <= status_nxt;
      if (arm_rise_c) begin
        we_all_q <= ctrl_in[CTRL_WE_ALL];
        circ_q   <= ctrl_in[CTRL_CIRC];
      end
      if (wr_c) begin
        bram_addr <= cnt;
        bram_din  <= din;
      end
    end
  end

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl: expected BRAM writes are queued as stimulus is
// driven and popped by a write monitor; status words are checked at each step.
module tb_snap_capture_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  logic              user_clk;
  logic              user_rst_n;
  logic [31:0]       ctrl_in;
  logic              trig;
  logic              stop;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  snap_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl_in    (ctrl_in),
    .trig       (trig),
    .stop       (stop),
    .din        (din),
    .din_valid  (din_valid),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_din   (bram_din),
    .status_out (status_out)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic push(input int a, input logic [DATA_W-1:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endtask

  // Every BRAM write must match the oldest queued expectation
  always @(negedge user_clk) begin
    if (bram_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bram_we), 32'(0));
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bram_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("wr_data", bram_din, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    user_rst_n = 1'b1;
    ctrl_in = '0; trig = 1'b0; stop = 1'b0; din = '0; din_valid = 1'b0;
    #1 user_rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_status", status_out, 32'h0);
    chk("reset_we", 32'(bram_we), 32'h0);
    user_rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_status", status_out, 32'h0);

    // Triggered full capture
    ctrl_in = 32'h1; din_valid = 1'b1; din = 32'd100;
    tick();
    chk("armed_status", status_out, 32'h4000_0000);
    for (int i = 1; i < 5; i++) begin
      din = 32'(100 + i);
      tick();
    end
    chk("armed_wait", status_out, 32'h4000_0000);
    for (int i = 0; i < 16; i++) begin
      trig = (i == 0);
      din  = 32'(200 + i);
      push(i, din);
      tick();
      if (i == 0) chk("trig_sample", status_out, 32'h4000_0000);
      if (i == 7) chk("mid_capture", status_out, 32'h4000_0007);
    end
    trig = 1'b0;
    chk("full_done", status_out, 32'h8000_000F);
    for (int i = 0; i < 10; i++) begin
      trig = (i == 3);
      din  = 32'(250 + i);
      tick();
    end
    trig = 1'b0;
    chk("done_hold", status_out, 32'h8000_000F);
    chk("din_hold", bram_din, 32'd215);

    // Immediate trigger with valid gating
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'h3;
    tick();
    chk("imm_start", status_out, 32'h4000_0000);
    begin
      int a;
      a = 0;
      for (int i = 0; i < 8; i++) begin
        din_valid = (i % 2 == 0);
        din       = 32'(300 + i);
        if (din_valid) begin
          push(a, din);
          a++;
        end
        tick();
      end
    end
    chk("gated_status", status_out, 32'h4000_0003);

    // Re-arm mid-capture after 7 writes
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'(310 + i);
      push(4 + i, din);
      tick();
    end
    chk("seven_writes", status_out, 32'h4000_0006);
    ctrl_in = 32'h0; din_valid = 1'b0;
    tick();
    ctrl_in = 32'h3; din_valid = 1'b1; din = 32'd399;
    tick();
    chk("rearm_restart", status_out, 32'h4000_0000);
    din = 32'd400; push(0, din);
    tick();
    din = 32'd401; push(1, din);
    tick();
    chk("rearm_count", status_out, 32'h4000_0001);

    // Circular capture with stop
    ctrl_in = 32'h0; din_valid = 1'b0;
    tick();
    ctrl_in = 32'hF;
    tick();
    chk("circ_start", status_out, 32'h4000_0000);
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 32'(500 + i);
      push(i % 16, din);
      tick();
      if (i == 15) chk("circ_wrap", status_out, 32'h6000_000F);
    end
    chk("circ_20", status_out, 32'h6000_0003);
    stop = 1'b1; din = 32'd999;
    tick();
    stop = 1'b0;
    chk("circ_stop", status_out, 32'hA000_0003);

    // Held arm level must not re-arm
    for (int i = 0; i < 100; i++) begin
      trig = (i % 10 == 0);
      din  = 32'(700 + i);
      tick();
    end
    trig = 1'b0;
    chk("held_arm", status_out, 32'hA000_0003);
    chk("held_din", bram_din, 32'd519);

    // Stop coinciding with the wrap write
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'hF;
    tick();
    chk("rearm_clear", status_out, 32'h4000_0000);
    for (int i = 0; i < 15; i++) begin
      din = 32'(600 + i);
      push(i, din);
      tick();
    end
    chk("pre_wrap", status_out, 32'h4000_000E);
    stop = 1'b1; din = 32'd998;
    tick();
    stop = 1'b0;
    chk("stop_at_wrap", status_out, 32'h8000_000E);

    // Stop ignored in ARMED; we_all writes without valid
    ctrl_in = 32'h0; din_valid = 1'b0;
    tick();
    ctrl_in = 32'hD;
    tick();
    chk("armed_circ", status_out, 32'h4000_0000);
    stop = 1'b1;
    tick();
    chk("stop_ignored_armed", status_out, 32'h4000_0000);
    stop = 1'b0; trig = 1'b1; din = 32'd800; push(0, din);
    tick();
    trig = 1'b0;
    chk("we_all_trig", status_out, 32'h4000_0000);
    stop = 1'b1; din = 32'd801;
    tick();
    stop = 1'b0;
    chk("we_all_stop", status_out, 32'h8000_0000);

    // Stop before any write: done with address 0
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'hB;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_no_write", status_out, 32'h8000_0000);

    // Async reset mid-capture
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'h3; din_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      din = 32'(900 + i);
      push(i, din);
      tick();
    end
    @(negedge user_clk);
    #1;
    user_rst_n = 1'b0;
    #1;
    chk("async_status", status_out, 32'h0);
    chk("async_we", 32'(bram_we), 32'h0);
    chk("async_addr", 32'(bram_addr), 32'h0);
    chk("async_din", bram_din, 32'h0);
    ctrl_in = 32'h0; din_valid = 1'b0;
    tick();
    tick();
    user_rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_status", status_out, 32'h0);

    @(negedge user_clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
